// File: rtl/pe_fetch.sv
// Sequential bus fetch front end: single-outstanding read master feeding a
// DEPTH-entry prefetch FIFO, with redirect flush and registered head outputs.
module pe_fetch #(
  parameter int                AD_LEN    = 32,
  parameter int                BUS_WIDTH = 32,
  parameter int                DEPTH     = 4,
  parameter logic [AD_LEN-1:0] RESET_AD  = '0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [BUS_WIDTH-1:0] bus_data_i,
  input  logic                 bus_ack_i,
  output logic                 bus_req_o,
  output logic [AD_LEN-1:0]    bus_ad_o,
  input  logic                 redirect_i,
  input  logic [AD_LEN-1:0]    redirect_ad_i,
  output logic [BUS_WIDTH-1:0] insn_o,
  output logic [AD_LEN-1:0]    insn_ad_o,
  output logic                 insn_valid_o,
  input  logic                 insn_ready_i
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam int                OFF_W   = $clog2(BUS_WIDTH / 8);
  localparam logic [AD_LEN-1:0] STEP    = AD_LEN'(BUS_WIDTH / 8);
  localparam logic [AD_LEN-1:0] AD_MASK = {AD_LEN{1'b1}} << OFF_W;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic                 req_reg, req_next;
  logic [AD_LEN-1:0]    ad_reg, ad_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [BUS_WIDTH-1:0] insn_reg, insn_next;
  logic [AD_LEN-1:0]    insn_ad_reg, insn_ad_next;
  logic                 valid_reg, valid_next;

  logic [BUS_WIDTH-1:0] mem_data [DEPTH];
  logic [AD_LEN-1:0]    mem_ad   [DEPTH];

  logic push, pop, wr_en;

  // An ack only counts against a request we actually issued.
  assign push  = bus_ack_i && req_reg;
  assign pop   = valid_reg && insn_ready_i;
  assign wr_en = push && !redirect_i;

  always_comb begin
    state_next   = state_reg;
    req_next     = req_reg;
    ad_next      = ad_reg;
    count_next   = count_reg;
    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    insn_next    = '0;
    insn_ad_next = '0;
    valid_next   = 1'b0;

    if (redirect_i) begin
      state_next  = ST_FETCH;
      req_next    = 1'b0;
      ad_next     = redirect_ad_i & AD_MASK;
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
        ad_next     = ad_reg + STEP;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

      case (state_reg)
        ST_FETCH: if (push && !pop && count_reg == CNT_W'(DEPTH - 1)) state_next = ST_FULL;
        ST_FULL:  if (pop) state_next = ST_FETCH;
        default:  state_next = ST_FETCH;
      endcase
      req_next = (state_next == ST_FETCH);

      // A word pushed into an otherwise empty buffer bypasses the array.
      if (count_next != '0) begin
        valid_next = 1'b1;
        if (push && count_next == CNT_W'(1)) begin
          insn_next    = bus_data_i;
          insn_ad_next = ad_reg;
        end else begin
          insn_next    = mem_data[rd_ptr_next];
          insn_ad_next = mem_ad[rd_ptr_next];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_data[wr_ptr_reg] <= bus_data_i;
      mem_ad[wr_ptr_reg]   <= ad_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= ST_FETCH;
      req_reg     <= 1'b0;
      ad_reg      <= RESET_AD;
      count_reg   <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      insn_reg    <= '0;
      insn_ad_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      req_reg     <= req_next;
      ad_reg      <= ad_next;
      count_reg   <= count_next;
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      insn_reg    <= insn_next;
      insn_ad_reg <= insn_ad_next;
      valid_reg   <= valid_next;
    end
  end

  assign bus_req_o    = req_reg;
  assign bus_ad_o     = ad_reg;
  assign insn_o       = insn_reg;
  assign insn_ad_o    = insn_ad_reg;
  assign insn_valid_o = valid_reg;

endmodule

// File: tb/tb_pe_fetch.sv
// Directed plus randomized bench for pe_fetch against a queue-based model of
// the fetch stream (expected words, fetch address, request/full behaviour).
module tb_pe_fetch;
  localparam int          AD_LEN    = 32;
  localparam int          BUS_WIDTH = 32;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_AD  = 32'h100;
  localparam logic [31:0] STEP      = 32'd4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic        bus_req_o;
  logic [31:0] bus_ad_o;
  logic        redirect_i;
  logic [31:0] redirect_ad_i;
  logic [31:0] insn_o;
  logic [31:0] insn_ad_o;
  logic        insn_valid_o;
  logic        insn_ready_i;

  always #5 clk_i = ~clk_i;

  pe_fetch #(
    .AD_LEN   (AD_LEN),
    .BUS_WIDTH(BUS_WIDTH),
    .DEPTH    (DEPTH),
    .RESET_AD (RESET_AD)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .bus_data_i   (bus_data_i),
    .bus_ack_i    (bus_ack_i),
    .bus_req_o    (bus_req_o),
    .bus_ad_o     (bus_ad_o),
    .redirect_i   (redirect_i),
    .redirect_ad_i(redirect_ad_i),
    .insn_o       (insn_o),
    .insn_ad_o    (insn_ad_o),
    .insn_valid_o (insn_valid_o),
    .insn_ready_i (insn_ready_i)
  );

  // Model: buffered word addresses in order, next fetch address, request flag.
  logic [31:0] m_q[$];
  logic [31:0] m_ad   = RESET_AD;
  logic        m_req  = 1'b0;
  logic        m_full = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C5A_9600;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bus_req", {31'b0, bus_req_o}, {31'b0, m_req});
    chk("bus_ad", bus_ad_o, m_ad);
    chk("insn_valid", {31'b0, insn_valid_o}, {31'b0, m_q.size() > 0});
    chk("insn", insn_o, (m_q.size() > 0) ? word_at(m_q[0]) : 32'h0);
    chk("insn_ad", insn_ad_o, (m_q.size() > 0) ? m_q[0] : 32'h0);
  endtask

  task automatic step(input logic rst, input logic ack, input logic rdy,
                      input logic redir, input logic [31:0] rad);
    logic push, pop;
    reset_i       = rst;
    redirect_i    = redir;
    redirect_ad_i = rad;
    insn_ready_i  = rdy;
    bus_ack_i     = ack && m_req;
    bus_data_i    = bus_ack_i ? word_at(m_ad) : $urandom;
    @(posedge clk_i);
    if (rst) begin
      m_q.delete();
      m_ad   = RESET_AD;
      m_req  = 1'b0;
      m_full = 1'b0;
    end else if (redir) begin
      m_q.delete();
      m_ad   = rad & ~(STEP - 32'd1);
      m_req  = 1'b0;
      m_full = 1'b0;
    end else begin
      pop  = (m_q.size() > 0) && rdy;
      push = bus_ack_i;
      if (pop) begin
        $display("pop  ad=%08h data=%08h", m_q[0], word_at(m_q[0]));
        void'(m_q.pop_front());
      end
      if (push) begin
        m_q.push_back(m_ad);
        m_ad = m_ad + STEP;
      end
      if (!m_full && push && !pop && m_q.size() == DEPTH) m_full = 1'b1;
      else if (m_full && pop) m_full = 1'b0;
      m_req = !m_full;
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] rad;
    int          r;
    reset_i       = 1'b1;
    bus_ack_i     = 1'b0;
    bus_data_i    = '0;
    redirect_i    = 1'b0;
    redirect_ad_i = '0;
    insn_ready_i  = 1'b0;

    // Reset state, then first request in cycle 1 after release
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("first_req", {31'b0, bus_req_o}, 32'h1);
    chk("first_ad", bus_ad_o, 32'h100);

    // Streaming with constant ack and ready
    repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Fill to FULL with ready low, single pop, refill
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_req", {31'b0, bus_req_o}, 32'h0);
    chk("full_ad", bus_ad_o, 32'h110);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("refetch_req", {31'b0, bus_req_o}, 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("refull_req", {31'b0, bus_req_o}, 32'h0);
    chk("refull_ad", bus_ad_o, 32'h114);
    repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with 3 buffered entries and an ack in the same cycle
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h203);
    chk("redir_valid", {31'b0, insn_valid_o}, 32'h0);
    chk("redir_req", {31'b0, bus_req_o}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_ad", bus_ad_o, 32'h200);
    repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Address wrap
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_ad", bus_ad_o, 32'h0);
    chk("wrap_insn_ad", insn_ad_o, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_insn_ad0", insn_ad_o, 32'h0);

    // Reset in mid-stream
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("midrst_req", {31'b0, bus_req_o}, 32'h0);
    chk("midrst_valid", {31'b0, insn_valid_o}, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("midrst_ad", bus_ad_o, 32'h100);
    chk("midrst_req1", {31'b0, bus_req_o}, 32'h1);

    // Randomized traffic with alternating consumer pressure
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 199);
      rad = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r == 0, $urandom_range(0, 3) != 0,
           ((i / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           (r >= 1 && r <= 6), rad);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
